// File: rtl/btn_oneshot_array.sv
// N-channel active-low pushbutton conditioner: 2-flop sync, debounce FSM, press tick, debounced level.
// Define BTN_AUTOREPEAT_EN to build the per-channel hold auto-repeat.
module btn_oneshot_array #(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned DEB_CNT      = 4,
  parameter int unsigned REPEAT_DELAY = 20,
  parameter int unsigned REPEAT_RATE  = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N_CH-1:0] pbn,
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] level
);

  typedef enum logic [1:0] {StIdle, StDebPress, StPressed, StDebRelease} state_e;

  localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEB_CNT - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DelayLast = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RateLast  = CNT_W'(REPEAT_RATE - 1);
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]       sync_q;
    logic             pb_s;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;
    logic             level_q;
`ifdef BTN_AUTOREPEAT_EN
    logic [CNT_W-1:0] hold_q;
    logic             rep_q;  // first repeat already issued; later ticks use REPEAT_RATE
`endif

    // Inverted so the synchronised value is 1 while the button is pressed.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[0], ~pbn[i]};
      end
    end

    assign pb_s = sync_q[1];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        tick_q  <= 1'b0;
        level_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        hold_q  <= '0;
        rep_q   <= 1'b0;
`endif
      end else begin
        tick_q <= 1'b0;
        case (state_q)
          StIdle: begin
            if (pb_s) begin
              state_q <= StDebPress;
              cnt_q   <= '0;
            end
          end
          StDebPress: begin
            if (!pb_s) begin
              state_q <= StIdle;
            end else if (cnt_q == DebLast) begin
              state_q <= StPressed;
              tick_q  <= 1'b1;
              level_q <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
              hold_q  <= '0;
              rep_q   <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StPressed: begin
            if (!pb_s) begin
              state_q <= StDebRelease;
              cnt_q   <= '0;
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (!rep_q) begin
              if (hold_q == DelayLast) begin
                tick_q <= 1'b1;
                hold_q <= '0;
                rep_q  <= 1'b1;
              end else begin
                hold_q <= hold_q + 1'b1;
              end
            end else if (hold_q == RateLast) begin
              tick_q <= 1'b1;
              hold_q <= '0;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
`endif
          end
          StDebRelease: begin
            if (pb_s) begin
              state_q <= StPressed;
            end else if (cnt_q == DebLast) begin
              state_q <= StIdle;
              level_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
              hold_q  <= '0;
              rep_q   <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end

    assign tick[i]  = tick_q;
    assign level[i] = level_q;
  end

endmodule
